mem_stream_reader: RTL and testbench
====================================

// Module: mem_stream_reader
// PURPOSE
//  Read-side engine for the single-port-write/async-read memory block. On a start
//  command it walks a contiguous address window, drives the memory read address and
//  streams each word out on a valid/ready interface. It also pulses done when the
//  last word has been accepted. It sits between the memory and the downstream
//  datapath consumer.
// PARAMETERS
//  WIDTH  16              data word width, equal to the memory WIDTH
//  SIZE   64              memory depth in words, equal to the memory SIZE
//  LSIZE  $clog2(SIZE)    address width
// PORTS
//  clk         in   1        clock, all state updates on posedge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        command strobe; sampled only in IDLE
//  start_addr  in   LSIZE    first word address of the burst
//  length      in   LSIZE+1  number of words to stream; 0 is legal
//  busy        out  1        high while in STREAM
//  done        out  1        one-cycle pulse after the burst completes
//  rd_addr     out  LSIZE    to memory rd_addr
//  mem_data    in   WIDTH    from memory data_out (combinational read of rd_addr)
//  m_valid     out  1        output word valid
//  m_ready     in   1        downstream accepts a word when m_valid&&m_ready
//  m_data      out  WIDTH    output word (registered)
// BEHAVIOUR
//  - Reset, asynchronous and immediate, also mid-burst:
//    state=IDLE, busy=0, done=0, m_valid=0, m_data=0, rd_addr=0, remaining count=0.
//  - FSM IDLE -> STREAM -> DONE -> IDLE.
//    IDLE:   if start: rd_addr<=start_addr, cnt<=length. Go to STREAM if length!=0,
//            otherwise go to DONE (no word is emitted).
//    STREAM: load condition is cnt!=0 && (!m_valid || m_ready).
//            On load: m_data<=mem_data, m_valid<=1, rd_addr<=rd_addr+1, cnt<=cnt-1.
//            If m_valid&&m_ready and no load: m_valid<=0.
//            Exit to DONE when cnt==0 and the final word is accepted (m_valid&&m_ready).
//    DONE:   done=1 for exactly one cycle, then go to IDLE.
//  - Address wrap: rd_addr increments modulo SIZE (SIZE-1 -> 0), including
//    non-power-of-2 SIZE. length>SIZE re-reads wrapped words.
//  - Latency: start sampled at edge E0 -> rd_addr valid after E0 -> m_valid high
//    after E1. With m_ready held high, throughput is 1 word/clk, with no bubbles.
//  - Backpressure: while m_valid&&!m_ready, m_data, m_valid, rd_addr and cnt hold.
//  - start while busy or in DONE: ignored, with no effect on the burst.
//  - done and m_valid are never high in the same cycle. done rises the cycle after
//    the last handshake.
//  - Memory writes to the current rd_addr before the load edge are visible in m_data
//    (read-through). Later writes do not alter an already loaded m_data.
//  - cnt is LSIZE+1 bits wide and never underflows.
// TESTING
//  1. Preload mem[i]=i+16'h100. start, addr=4, len=3, m_ready=1 -> m_data 0x104,
//     0x105, 0x106 on 3 consecutive cycles, then done pulses 1 cycle, busy=0.
//  2. Wrap: addr=62, len=4, SIZE=64 -> rd_addr 62,63,0,1 and data mem[62],mem[63],
//     mem[0],mem[1].
//  3. Backpressure: len=4, m_ready toggles 1,0,0,1,... -> every word delivered exactly
//     once, in order; m_data stable whenever m_valid&&!m_ready.
//  4. len=0 -> no m_valid; done pulses at the 2nd edge after start; busy never high.
//  5. Assert rst mid-burst after word 2 of 8 -> outputs reach reset values with no
//     clk edge required. A new start addr=0, len=2 then runs cleanly.
//  6. start re-asserted every cycle during a len=5 burst -> exactly 5 words and
//     1 done pulse.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Streams a contiguous window of an async-read memory out over a valid/ready port.
// The window wraps modulo SIZE. done pulses once after the final word is accepted.
module mem_stream_reader #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    parameter int LSIZE = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LSIZE-1:0] start_addr,
    input  logic [LSIZE:0]   length,
    output logic             busy,
    output logic             done,
    output logic [LSIZE-1:0] rd_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [LSIZE-1:0]   rd_addr_reg, rd_addr_next;
    logic [LSIZE:0]     cnt_reg, cnt_next;
    logic               m_valid_reg, m_valid_next;
    logic [WIDTH-1:0]   m_data_reg, m_data_next;
    logic [LSIZE-1:0]   addr_inc;
    logic               load;

    // Explicit wrap so non-power-of-two depths also roll over at SIZE-1.
    assign addr_inc = (rd_addr_reg == LSIZE'(SIZE - 1)) ? '0 : rd_addr_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rd_addr_reg <= '0;
            cnt_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            rd_addr_reg <= rd_addr_next;
            cnt_reg     <= cnt_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_addr_next = rd_addr_reg;
        cnt_next     = cnt_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    rd_addr_next = start_addr;
                    cnt_next     = length;
                    state_next   = (length != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                // Refill the output register whenever it is empty or being drained.
                load = (cnt_reg != '0) && (!m_valid_reg || m_ready);
                if (load) begin
                    m_data_next  = mem_data;
                    m_valid_next = 1'b1;
                    rd_addr_next = addr_inc;
                    cnt_next     = cnt_reg - 1'b1;
                end else if (m_valid_reg && m_ready) begin
                    m_valid_next = 1'b0;
                    if (cnt_reg == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == STREAM);
    assign done    = (state_reg == DONE);
    assign rd_addr = rd_addr_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: stimulus pushes expected words, a negedge
// monitor pops and compares on every handshake and polices done/backpressure rules.
module tb_mem_stream_reader;

    localparam int WIDTH = 16;
    localparam int SIZE  = 64;
    localparam int LSIZE = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LSIZE-1:0] start_addr;
    logic [LSIZE:0]   length;
    logic             busy;
    logic             done;
    logic [LSIZE-1:0] rd_addr;
    logic [WIDTH-1:0] mem_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    logic [WIDTH-1:0] mem [SIZE];
    logic [WIDTH-1:0] exp_q [$];

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    int pop_cnt   = 0;

    logic             stall_prev = 1'b0;
    logic             done_prev  = 1'b0;
    logic [WIDTH-1:0] data_prev  = '0;

    assign mem_data = mem[rd_addr];

    mem_stream_reader #(.WIDTH(WIDTH), .SIZE(SIZE), .LSIZE(LSIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .mem_data   (mem_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: handshakes pop the scoreboard; done and stall rules checked every cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_hold", {31'd0, m_valid}, 32'd1);
                chk("stall_data_hold", {16'd0, m_data}, {16'd0, data_prev});
            end
            if (done) begin
                done_cnt++;
                chk("done_single_pulse", {31'd0, done_prev}, 32'd0);
                chk("done_no_valid", {31'd0, m_valid}, 32'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
                end else begin
                    chk("word_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
                pop_cnt++;
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
            done_prev  = done;
        end
    end

    // Presents one start strobe right after a posedge; returns just after the sampling edge.
    task automatic do_start(input int addr, input int len);
        start      = 1'b1;
        start_addr = LSIZE'(addr);
        length     = (LSIZE+1)'(len);
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % SIZE]);
        exp_done++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt < exp_done; i++) @(negedge clk);
        chk("done_count", done_cnt, exp_done);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        int         p0;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        m_ready    = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i + 16'h100);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_data", {16'd0, m_data}, 0);
        chk("rst_addr", {26'd0, rd_addr}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic burst, latency and no bubbles
        m_ready = 1'b1;
        do_start(4, 3);
        @(negedge clk);
        chk("t1_lat_valid", {31'd0, m_valid}, 0);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_addr", {26'd0, rd_addr}, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_stream_valid", {31'd0, m_valid}, 1);
        end
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_busy_low", {31'd0, busy}, 0);
        wait_done(10);

        // 2: address wrap
        do_start(62, 4);
        @(negedge clk);
        chk("t2_addr", {26'd0, rd_addr}, 62);
        wait_done(20);

        // 3: backpressure pattern 1,0,0,1
        pat = 4'b1001;
        do_start(10, 4);
        for (int k = 0; k < 60 && done_cnt < exp_done; k++) begin
            m_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        wait_done(10);

        // 4: zero length
        do_start(30, 0);
        @(negedge clk);
        chk("t4_done_first", {31'd0, done}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("t4_done_gone", {31'd0, done}, 0);
        chk("t4_valid", {31'd0, m_valid}, 0);
        wait_done(5);

        // 5: asynchronous reset mid-burst
        p0 = pop_cnt;
        do_start(8, 8);
        for (int i = 0; i < 20 && pop_cnt < p0 + 2; i++) @(negedge clk);
        chk("t5_two_words", pop_cnt - p0, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", {31'd0, busy}, 0);
        chk("t5_rst_valid", {31'd0, m_valid}, 0);
        chk("t5_rst_data", {16'd0, m_data}, 0);
        chk("t5_rst_addr", {26'd0, rd_addr}, 0);
        chk("t5_rst_done", {31'd0, done}, 0);
        exp_q.delete();
        exp_done = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        do_start(0, 2);
        wait_done(10);

        // 6: start held high throughout a burst
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back(mem[20 + i]);
        exp_done++;
        start      = 1'b1;
        start_addr = 6'd20;
        length     = 7'd5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            start_addr = LSIZE'($urandom_range(0, SIZE - 1));
            length     = (LSIZE+1)'($urandom_range(1, 9));
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_words", pop_cnt - p0, 5);
        wait_done(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
